// File: rtl/vga_fetch_pkg.sv
// rtl/vga_fetch_pkg.sv - shared types and byte-lane constants for the frame-fetch controller
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int LANE_RED    = 0;
    localparam int LANE_GREEN  = 1;
    localparam int LANE_BLUE   = 2;
    localparam int LANE_BRIGHT = 3;

endpackage

// File: rtl/vga_fetch_fifo.sv
// rtl/vga_fetch_fifo.sv - show-ahead word FIFO with flush and free-slot count
module vga_fetch_fifo #(
    parameter int WIDTH     = 32,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   free
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = {1'b1, {FIFO_LOG2{1'b0}}};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_LOG2-1:0] wptr;
    logic [FIFO_LOG2-1:0] rptr;
    logic [FIFO_LOG2:0]   count;
    logic                 full;
    logic                 do_wr;
    logic                 do_pop;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);
    assign free   = DEPTH_CNT - count;
    assign do_pop = rd && !empty && !flush;
    assign do_wr  = wr && !full && !flush;
    // Blank output while empty so the display sees black rather than stale data
    assign rdata  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fetch_ctrl.sv
// rtl/vga_fetch_ctrl.sv - walks the frame buffer with single-word reads and feeds the display FIFO
module vga_fetch_ctrl
    import vga_fetch_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int FRAME_WORDS = 38400,
    parameter int FIFO_LOG2   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              vga_vsync,
    input  logic              rd,
    output logic [7:0]        red_byte,
    output logic [7:0]        green_byte,
    output logic [7:0]        blue_byte,
    output logic [7:0]        bright_byte,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [31:0]       bus_data,
    output logic              underrun
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               vs_meta, vs_sync, vs_prev;
    logic               frame_start;
    logic               restart;
    logic               flush;
    logic               fifo_wr;
    logic               fifo_empty;
    logic [FIFO_LOG2:0] fifo_free;
    logic [31:0]        head;

    // vsync idles high, so the synchronizer resets high to avoid a spurious frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= vga_vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_start = vs_prev && !vs_sync;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        req_d   = req_q && !bus_ack;
        fifo_wr = 1'b0;
        restart = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                restart = frame_start;
            end
            FETCH: begin
                if (frame_start) begin
                    if (req_q && !bus_ack) begin
                        state_d = DRAIN;
                        flush   = 1'b1;
                    end else begin
                        restart = 1'b1;
                    end
                end else begin
                    if (req_q && bus_ack) begin
                        fifo_wr = 1'b1;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    // A request is only raised with no request outstanding, so one free slot suffices
                    if (cnt_q == FRAME_CNT) begin
                        state_d = DONE;
                    end else if (!req_q && fifo_free != '0) begin
                        req_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus_ack) begin
                    restart = 1'b1;
                end else begin
                    flush = frame_start;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (restart) begin
            flush   = 1'b1;
            ptr_d   = base_addr;
            cnt_d   = '0;
            req_d   = 1'b0;
            state_d = enable ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            underrun <= 1'b0;
        end else if (rd && fifo_empty) begin
            underrun <= 1'b1;
        end
    end

    vga_fetch_fifo #(
        .WIDTH     (32),
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wr    (fifo_wr),
        .wdata (bus_data),
        .rd    (rd),
        .rdata (head),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    assign bus_req     = req_q;
    assign bus_addr    = ptr_q;
    assign red_byte    = head[LANE_RED*8    +: 8];
    assign green_byte  = head[LANE_GREEN*8  +: 8];
    assign blue_byte   = head[LANE_BLUE*8   +: 8];
    assign bright_byte = head[LANE_BRIGHT*8 +: 8];

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// tb/tb_vga_fetch_ctrl.sv - directed vectors and scoreboard for vga_fetch_ctrl
module tb_vga_fetch_ctrl;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic          vga_vsync;
    logic          rd;
    logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic          bus_ack;
    logic [31:0]   bus_data;
    logic          underrun;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_q[$];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [7:0]  br;
    } lane_vec_t;

    lane_vec_t lanes[5];

    always #5 clk = ~clk;

    vga_fetch_ctrl #(
        .ADDR_W      (AW),
        .FRAME_WORDS (20),
        .FIFO_LOG2   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .base_addr   (base_addr),
        .vga_vsync   (vga_vsync),
        .rd          (rd),
        .red_byte    (red_byte),
        .green_byte  (green_byte),
        .blue_byte   (blue_byte),
        .bright_byte (bright_byte),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_data    (bus_data),
        .underrun    (underrun)
    );

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return {~a[7:0], a[7:0] + 8'd3, a[15:8], a[7:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_head(input string name);
        logic [31:0] exp;
        exp = (model_q.size() != 0) ? model_q[0] : 32'h0;
        check(name, {bright_byte, blue_byte, green_byte, red_byte}, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pop();
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic wait_req(input string name);
        int w;
        w = 0;
        while (!bus_req && w < 50) begin
            step();
            w++;
        end
        check(name, bus_req, 1);
    endtask

    task automatic serve(input logic [AW-1:0] exp_addr, input int delay, input logic [31:0] data,
                         input bit with_rd, input bit keep);
        wait_req("req_seen");
        if (!bus_req) return;
        check("req_addr", bus_addr, exp_addr);
        repeat (delay) step();
        if (delay > 0) begin
            check("req_hold", {bus_req, bus_addr}, {1'b1, exp_addr});
        end
        bus_ack  = 1'b1;
        bus_data = data;
        rd       = with_rd;
        step();
        bus_ack  = 1'b0;
        bus_data = '0;
        rd       = 1'b0;
        if (with_rd && model_q.size() != 0) void'(model_q.pop_front());
        if (keep) model_q.push_back(data);
        check("req_drop", bus_req, 0);
    endtask

    task automatic expect_idle(input int n, input string name);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            step();
            if (bus_req) seen = 1'b1;
        end
        check(name, seen, 0);
    endtask

    task automatic vsync_pulse();
        vga_vsync = 1'b0;
        repeat (6) step();
        vga_vsync = 1'b1;
        repeat (3) step();
        model_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit stable;

        lanes[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        lanes[1] = '{32'hFF000000, 8'h00, 8'h00, 8'h00, 8'hFF};
        lanes[2] = '{32'h000000FF, 8'hFF, 8'h00, 8'h00, 8'h00};
        lanes[3] = '{32'h80C0E0F0, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        lanes[4] = '{32'h5AA5C33C, 8'h3C, 8'hC3, 8'hA5, 8'h5A};

        reset     = 1'b1;
        enable    = 1'b1;
        base_addr = 30'h1000;
        vga_vsync = 1'b1;
        rd        = 1'b0;
        bus_ack   = 1'b0;
        bus_data  = '0;
        repeat (3) step();
        check("reset_req", bus_req, 0);
        check("reset_addr", bus_addr, 0);
        check_head("reset_bytes");
        check("reset_underrun", underrun, 0);
        reset = 1'b0;
        step();

        pop();
        check("underrun_set", underrun, 1);
        check_head("underrun_blank");

        // Frame 1: fill the FIFO, then top it up until the 20-word frame is complete
        vsync_pulse();
        check("underrun_cleared", underrun, 0);
        for (int i = 0; i < 16; i++) begin
            serve(30'h1000 + i, i % 3, word_of(30'h1000 + i), 1'b0, 1'b1);
            check_head("fill_head");
        end
        expect_idle(10, "full_no_req");
        pop();
        check_head("pop_head");
        for (int i = 16; i < 20; i++) begin
            serve(30'h1000 + i, 0, word_of(30'h1000 + i), 1'b0, 1'b1);
            if (i < 19) begin
                pop();
                check_head("stream_head");
            end
        end
        pop();
        pop();
        expect_idle(10, "done_no_req");
        while (model_q.size() != 0) begin
            pop();
            check_head("drain_fifo_head");
        end
        pop();
        check("underrun_again", underrun, 1);
        check_head("empty_blank");

        // Frame 2: new base, rd coincident with ack at occupancy 3
        base_addr = 30'h2000;
        vsync_pulse();
        check("underrun_clear2", underrun, 0);
        for (int i = 0; i < 3; i++) begin
            serve(30'h2000 + i, 0, word_of(30'h2000 + i), 1'b0, 1'b1);
        end
        serve(30'h2003, 0, word_of(30'h2003), 1'b1, 1'b1);
        check_head("rd_ack_head");
        for (int i = 0; i < 3; i++) begin
            pop();
            check_head("rd_ack_pop");
        end
        check("occupancy_three", model_q.size(), 0);
        check("no_underrun_occ", underrun, 0);

        // vsync falls while a request is held off
        wait_req("drain_req_up");
        base_addr = 30'h3000;
        vga_vsync = 1'b0;
        stable = 1'b1;
        repeat (8) begin
            step();
            if (!(bus_req === 1'b1 && bus_addr === 30'h2004)) stable = 1'b0;
        end
        check("drain_hold", stable, 1);
        bus_ack  = 1'b1;
        bus_data = 32'hDEADBEEF;
        step();
        bus_ack  = 1'b0;
        bus_data = '0;
        check_head("drain_discard");
        stable = 1'b1;
        repeat (3) begin
            step();
            if ({bright_byte, blue_byte, green_byte, red_byte} !== 32'h0) stable = 1'b0;
        end
        check("drain_stays_blank", stable, 1);
        vga_vsync = 1'b1;

        for (int i = 0; i < 5; i++) begin
            serve(30'h3000 + i, i % 2, lanes[i].data, 1'b0, 1'b1);
            check("lane_red", red_byte, lanes[i].r);
            check("lane_green", green_byte, lanes[i].g);
            check("lane_blue", blue_byte, lanes[i].b);
            check("lane_bright", bright_byte, lanes[i].br);
            pop();
            check_head("lane_blank");
        end

        // Frame start while disabled, arriving mid-request: drain, then stay idle
        enable    = 1'b0;
        vga_vsync = 1'b0;
        repeat (6) step();
        serve(30'h3005, 0, 32'hFFFFFFFF, 1'b0, 1'b0);
        vga_vsync = 1'b1;
        check_head("disabled_blank");
        expect_idle(15, "disabled_no_req");

        // Reset abandons an outstanding request
        enable    = 1'b1;
        base_addr = 30'h0ABC;
        vsync_pulse();
        wait_req("restart_req");
        check("restart_addr", bus_addr, 30'h0ABC);
        reset = 1'b1;
        step();
        check("midreset_req", bus_req, 0);
        check("midreset_addr", bus_addr, 0);
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fetch_ctrl.md
# vga_fetch_ctrl

Frame-fetch controller that sequences video memory reads for the 640x480 bitmap display. It runs in the CPU clock domain and walks a frame buffer from a programmable base address. It issues single-word bus reads and buffers the returned words in a small show-ahead FIFO. It presents the head word as red/green/blue/bright bytes to the pixel-clock display, which consumes one word per `rd` pulse. Display vertical sync restarts the frame walk.

## Interface
Parameters:
- `ADDR_W`, 30: word-address width of the bus.
- `FRAME_WORDS`, 38400: words fetched per frame (80 words/line x 480 lines; 1 word = 8 pixels x 4 planes).
- `FIFO_LOG2`, 4: FIFO depth = 2^FIFO_LOG2 words.

Ports:
- `clk` in 1: CPU clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: fetching allowed; sampled at frame start only.
- `base_addr` in ADDR_W: frame base word address; sampled at frame start.
- `vga_vsync` in 1: active-low vsync from the pixel domain; asynchronous, synchronized internally.
- `rd` in 1: one-`clk` pulse from the display; pops the FIFO head.
- `red_byte`, `green_byte`, `blue_byte`, `bright_byte` out 8 each: FIFO head.
- `bus_req` out 1: read request.
- `bus_addr` out ADDR_W: read word address.
- `bus_ack` in 1: read complete; `bus_data` is valid in the same cycle.
- `bus_data` in 32: read data.
- `underrun` out 1: sticky flag; set when `rd` arrives while the FIFO is empty.

## Operation
- Sync input: 2-flop synchronizer on `vga_vsync`, plus a third flop for edge detection. `frame_start` = synchronized falling edge (sync assertion).
- Byte lanes: `bus_data[7:0]` → red, `[15:8]` → green, `[23:16]` → blue, `[31:24]` → bright.
- FSM states:
  - IDLE: `bus_req` = 0.
    - On `frame_start`: flush the FIFO, load `ptr` ← `base_addr` and `cnt` ← 0, and clear `underrun`.
    - Then go to FETCH if `enable`=1, otherwise stay in IDLE.
  - FETCH:
    - Assert `bus_req` with `bus_addr`=`ptr` when free slots ≥ 1. At most one request is outstanding.
    - On `bus_ack`: write the word, `ptr`+1 (wraps modulo 2^ADDR_W), `cnt`+1.
    - When `cnt` reaches FRAME_WORDS, go to DONE.
  - DONE: `bus_req` = 0. On `frame_start`, take the same restart action as IDLE.
  - DRAIN: entered when `frame_start` occurs while `bus_req`=1 without `bus_ack`.
    - Hold `bus_req` and `bus_addr` until `bus_ack`, then discard the data.
    - Then restart as IDLE does, using `base_addr`/`enable` as sampled at the ack cycle.
- `frame_start` in the same cycle as `bus_ack` in FETCH: discard the data and restart immediately (no DRAIN).
- Request rules:
  - Once raised, `bus_req` and `bus_addr` stay stable until `bus_ack`.
  - `bus_req` drops in the cycle after the ack. The next request may assert in that same cycle.
- FIFO behaviour:
  - Show-ahead: output bytes equal the head word whenever the FIFO is non-empty, and 0x00 when empty (blank).
  - `rd` while empty: no pop, `underrun` ← 1.
  - `rd` and a write in the same cycle: both happen and the occupancy is unchanged. With the FIFO empty, the write happens and the pop is treated as an underrun.
  - A write is never issued when full, because free-slot accounting includes the outstanding request.
- The flush happens in the `frame_start` cycle: occupancy ← 0 and outputs 0 the next cycle. A `rd` in the flush cycle is ignored and does not set `underrun`.

## Timing
- Reset values: `bus_req`=0, `bus_addr`=0, all bytes 0x00, `underrun`=0; FSM in IDLE; FIFO empty; `ptr`=0; `cnt`=0.
- `vga_vsync` falling at the input → `frame_start` 3 `clk` later.
- `frame_start` in IDLE with `enable`=1 → `bus_req`=1 with `bus_addr`=`base_addr` on the 2nd cycle after `frame_start`.
- `bus_ack` → the word is visible on the outputs the next cycle if the FIFO was empty.
- `rd` → the next head word is visible the next cycle.
- Peak throughput: one word per 2 `clk` (req/ack cycle + gap), when the bus acks in the request's first cycle.
- Reset mid-operation: abandon any outstanding request immediately (the bus master must tolerate `bus_req` dropping) and return to the reset values.

## Structure
- Package `vga_fetch_pkg`:
  - state enum {IDLE, FETCH, DONE, DRAIN};
  - byte-lane constants `LANE_RED`=0, `LANE_GREEN`=1, `LANE_BLUE`=2, `LANE_BRIGHT`=3.
- Sub-module `vga_fetch_fifo`: synchronous show-ahead FIFO with parameters width 32 / depth 2^FIFO_LOG2.
  - Ports: `clk`, `reset`, `flush`, `wr`, `wdata`, `rd`, `rdata`, `empty`, `free` (count).
  - Occupancy counter is FIFO_LOG2+1 bits wide.
- Top level: synchronizer, FSM, `ptr`/`cnt` counters (`cnt` width = clog2(FRAME_WORDS+1)), free-slot check.

## Test plan
- Reset then vsync with `enable`=1, `base_addr`=0x1000, bus acking in 1 cycle: addresses 0x1000, 0x1001, … are requested until the FIFO is full (16 words), with no further `bus_req` until a `rd`.
- FRAME_WORDS=20 (test override), the display pops continuously: exactly 20 requests (0x1000–0x1013), then DONE with `bus_req`=0. The next vsync restarts at the then-current `base_addr`.
- Pop the empty FIFO: `underrun`=1 and outputs hold 0x00. `underrun` clears on the next `frame_start`.
- Bus holds the ack off 5 cycles and vsync falls mid-request: `bus_req`/`bus_addr` stay stable until the ack, the data (e.g. 0xDEADBEEF) never appears on the outputs, and the next request is `base_addr`.
- `rd` coincident with `bus_ack` at occupancy 3: occupancy stays 3, and the head advances to the 2nd word.
- `bus_data`=0x44332211 written into an empty FIFO: the next cycle shows red=0x11, green=0x22, blue=0x33, bright=0x44.
